// File: rtl/sr_flag_arbiter_pkg.sv
// Shared constants and helpers for the set/reset flag arbiter.
package sr_flag_arbiter_pkg;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // Ceiling log2, never below 1 so that index and grant fields always have a bit.
  function automatic int log2c(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping.
module rr_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = log2c(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  // Scan N positions starting at ptr; the first active request wins.
  always_comb begin : search
    logic found;
    int   j;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        gnt_id = IDW'(j);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Clocked flag bank written by several requesters through a round-robin arbiter.
// Opposite-op collisions on the same flag are serialised and reported on conflict.
module sr_flag_arbiter
  import sr_flag_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = log2c(NFLAG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr_all,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        op,
  input  logic [NREQ*IDXW-1:0]   idx,
  output logic [NREQ-1:0]        ack,
  output logic [NFLAG-1:0]       flags,
  output logic [log2c(NREQ)-1:0] grant_id,
  output logic                   conflict
);

  localparam int GW = log2c(NREQ);

  logic [GW-1:0]    ptr_p1;
  logic [NREQ-1:0]  req_p0;
  logic [NREQ-1:0]  gnt_p0;
  logic [GW-1:0]    gid_p0;
  logic             gnt_any_p0;
  logic [IDXW-1:0]  idx_g_p0;
  logic             op_g_p0;
  logic [NFLAG-1:0] mask_p0;
  logic             hit_p0;

  // Arbitration is only open when nothing higher priority owns the cycle.
  assign req_p0 = (!reset && en && !clr_all) ? req : '0;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (GW)
  ) u_arb (
    .req    (req_p0),
    .ptr    (ptr_p1),
    .gnt    (gnt_p0),
    .gnt_id (gid_p0)
  );

  assign ack        = gnt_p0;
  assign grant_id   = gid_p0;
  assign gnt_any_p0 = |gnt_p0;
  assign idx_g_p0   = idx[gid_p0*IDXW +: IDXW];
  assign op_g_p0    = op[gid_p0];

  // One-hot decode of the granted index; an out-of-range index decodes to nothing.
  always_comb begin
    mask_p0 = '0;
    for (int f = 0; f < NFLAG; f++)
      mask_p0[f] = gnt_any_p0 && (idx_g_p0 == IDXW'(f));
  end

  // A pending loser targeting the same in-range flag with the opposite op is a collision.
  always_comb begin
    hit_p0 = 1'b0;
    for (int j = 0; j < NREQ; j++)
      if ((GW'(j) != gid_p0) && req[j] &&
          (idx[j*IDXW +: IDXW] == idx_g_p0) && (op[j] != op_g_p0))
        hit_p0 = 1'b1;
    hit_p0 = hit_p0 && gnt_any_p0 && (|mask_p0);
  end

  // ---- commit stage: flag bank, round-robin pointer, conflict pulse ----
  // Reset wins, then enable freeze, then bulk clear, then the granted single-bit write.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags    <= '0;
      ptr_p1   <= '0;
      conflict <= 1'b0;
    end else if (!en) begin
      conflict <= 1'b0;
    end else if (clr_all) begin
      flags    <= '0;
      conflict <= 1'b0;
    end else begin
      conflict <= hit_p0;
      if (gnt_any_p0) begin
        unique case (op_g_p0)
          OP_SET:  flags <= flags | mask_p0;
          OP_CLR:  flags <= flags & ~mask_p0;
          default: flags <= flags;
        endcase
        ptr_p1 <= (gid_p0 == GW'(NREQ - 1)) ? '0 : gid_p0 + 1'b1;
      end
    end
  end

endmodule
